// File: rtl/gearbox_pkg.sv
// Shared constants and elaboration helpers for the width gearbox.
package gearbox_pkg;

    localparam int GB_MAX_W = 64;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/width_gearbox.sv
// Repacks IN_W-bit beats into OUT_W-bit words, MSB-first, with
// valid/ready on both sides and zero-padded end-of-frame flush.
module width_gearbox
    import gearbox_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last
);

    localparam int BUF_W = 2 * (IN_W + OUT_W);
    localparam int CNT_W = clog2_f(BUF_W + 1);

    localparam logic [CNT_W-1:0] IN_C   = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] OUT_C  = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] ROOM_C = CNT_W'(BUF_W - IN_W);

    if (IN_W < 1 || OUT_W < 1 || max_f(IN_W, OUT_W) > GB_MAX_W) begin : g_bad_w
        $error("width_gearbox: IN_W/OUT_W out of range");
    end

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             in_fire, out_fire;

    assign in_ready  = !last_q && (cnt_q <= ROOM_C);
    assign out_valid = (cnt_q >= OUT_C) || (last_q && cnt_q != '0);
    assign out_data  = buf_q[BUF_W-1 -: OUT_W];
    assign out_last  = last_q && (cnt_q <= OUT_C);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Pop happens first so an incoming beat lands right behind what remains.
    always_comb begin
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if (out_fire) begin
            buf_d = buf_q << OUT_W;
            cnt_d = (cnt_q > OUT_C) ? (cnt_q - OUT_C) : '0;
            if (out_last) last_d = 1'b0;
        end
        if (in_fire) begin
            buf_d = buf_d | ({in_data, {(BUF_W - IN_W){1'b0}}} >> cnt_d);
            cnt_d = cnt_d + IN_C;
            if (in_last) last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

endmodule
